xt_bus_fifo_target: RTL and testbench
=====================================

// Module: xt_bus_fifo_target
// PURPOSE
//  Generic 8-bit XT-bus I/O target: the responder end of the chipset bus (io_read_n/io_write_n,
//  address_enable_n, io_channel_ready, DMA request/acknowledge, IRQ). Exposes a 4-port register
//  window with RX/TX byte FIFOs toward a back-end byte stream. Wait-state insertion, single-transfer
//  DMA and a level IRQ. Sits beside PERIPHERALS; its data_bus_out feeds the chipset read mux.
// PARAMETERS
//  BASE_ADDR    20'h00300  I/O base; window = BASE_ADDR..BASE_ADDR+3 (address[19:2] compared)
//  FIFO_DEPTH   16         entries per FIFO, power of 2, >=2
//  WAIT_STATES  2          cycles io_channel_ready held low per accepted cycle (0 = none)
// PORTS
//  clock              in   1  single clock; all bus strobes synchronous to it
//  reset              in   1  synchronous, active-high
//  address            in  20  bus address
//  internal_data_bus  in   8  write data from bus
//  io_read_n          in   1  I/O read strobe, active low
//  io_write_n         in   1  I/O write strobe, active low
//  address_enable_n   in   1  0 = CPU cycle (decode enabled), 1 = DMA cycle
//  dma_acknowledge_n  in   1  DACK for this channel, active low
//  terminal_count_n   in   1  DMA TC, active low, sampled while DACK low
//  data_bus_out       out  8  read data
//  data_bus_out_from_chipset out 1  1 while this block drives read data
//  io_channel_ready   out  1  0 inserts wait states
//  dma_request        out  1  DRQ
//  interrupt_request  out  1  level IRQ
//  in_data/in_valid/in_ready     8/in/out  back-end -> RX FIFO (push when valid&ready)
//  out_data/out_valid/out_ready  8/out/in  TX FIFO -> back-end (pop when valid&ready)
// BEHAVIOUR
//  Reset: all outputs 0 except io_channel_ready=1, data_bus_out=8'hFF; FIFOs empty, regs 0, FSM IDLE.
//  Selected cycle: CPU = address_enable_n=0 & address hit & strobe low; DMA = dma_acknowledge_n=0 &
//   strobe low (address ignored, always data port). DMA read = RX pop, DMA write = TX push.
//  Registers: +0 DATA  R: pop RX; W: push TX.
//   +1 STATUS R: {4'b0, tc_seen, tx_dropped, tx_not_full, rx_not_empty}; W: 1 clears bits [3:2].
//   +2 CTRL   R/W: [0] rx_irq_en [1] tx_irq_en [2] dma_en [3] dma_dir (0 RX->mem, 1 mem->TX).
//   +3 COUNT  R: RX occupancy (saturates at 255); W ignored.
//  FSM: IDLE -> (selected strobe fall) WAIT -> after WAIT_STATES cycles ACTIVE (1 cycle)
//   -> HOLD until strobe high -> IDLE. WAIT_STATES=0 goes IDLE->ACTIVE directly.
//   io_channel_ready=0 exactly in WAIT. data_bus_out_from_chipset=1 in WAIT/ACTIVE/HOLD of reads.
//  Read data captured in ACTIVE and held through HOLD; FIFO pop / status clear commit in ACTIVE.
//  Write data sampled in ACTIVE (internal_data_bus stable from strobe fall).
//  Exactly one side effect per strobe low period regardless of length.
//  Read of empty RX: returns 8'hFF, no pop. Write to full TX: dropped, tx_dropped<=1.
//  Same-cycle back-end push + bus pop (or bus push + back-end pop): both happen, count unchanged;
//   in_ready = RX not full, evaluated before the pop; pointers wrap modulo FIFO_DEPTH.
//  DRQ (registered) = dma_en & ~tc_seen & (dma_dir ? tx_not_full : rx_not_empty) & FSM==IDLE
//   & dma_acknowledge_n; drops the cycle after DACK falls, re-evaluated after strobe rises.
//  TC: terminal_count_n=0 in a DMA ACTIVE cycle sets tc_seen (transfer still performed).
//  IRQ (registered, 1-cycle latency) = (rx_irq_en & rx_not_empty) | (tx_irq_en & TX empty)
//   | (dma_en & tc_seen).
//  Both strobes low together: ignored (no FSM entry). CPU and DACK both selecting: DACK wins.
//  Reset asserted mid-cycle: immediate return to reset state; a strobe already low at reset
//   release is ignored until it goes high (armed flag).
// TESTING
//  1 WAIT_STATES=2; OUT 0x300=0x5A -> io_channel_ready low exactly 2 cycles; out_data=0x5A,out_valid=1.
//  2 Push 0x11,0x22 via in_*; IN 0x303 -> 0x02; IN 0x300 twice -> 0x11,0x22; third IN -> 0xFF, STATUS bit0=0.
//  3 Fill TX 16 bytes, 17th OUT -> dropped, STATUS=0x04; OUT 0x301=0x04 -> STATUS bit2 cleared.
//  4 CTRL=0x04, RX holds 3 bytes; DACK+IOR x3, TC on third -> 3 bytes in order, DRQ low, STATUS bit3=1.
//  5 CTRL=0x01; push 1 byte -> interrupt_request=1 next cycle; pop it -> 0 one cycle later.
//  6 Reset during WAIT with io_read_n low -> ready=1, no pop; strobe high then low again -> normal read.

Source files
------------

// File: rtl/xt_bus_fifo_target_if.sv
// XT-bus chipset-side signal bundle for an 8-bit I/O target.
// The master drives strobes, address and write data. The slave returns read data, ready, DRQ and IRQ.
interface xt_bus_fifo_target_if;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_read_n;
  logic        io_write_n;
  logic        address_enable_n;
  logic        dma_acknowledge_n;
  logic        terminal_count_n;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_from_chipset;
  logic        io_channel_ready;
  logic        dma_request;
  logic        interrupt_request;

  modport master (
    output address, internal_data_bus, io_read_n, io_write_n,
           address_enable_n, dma_acknowledge_n, terminal_count_n,
    input  data_bus_out, data_bus_out_from_chipset, io_channel_ready,
           dma_request, interrupt_request
  );

  modport slave (
    input  address, internal_data_bus, io_read_n, io_write_n,
           address_enable_n, dma_acknowledge_n, terminal_count_n,
    output data_bus_out, data_bus_out_from_chipset, io_channel_ready,
           dma_request, interrupt_request
  );
endinterface

// File: rtl/xt_bus_fifo_target.sv
// XT-bus I/O target: 4-port register window over RX/TX byte FIFOs.
// Provides wait-state insertion, single-transfer DMA and a level IRQ.
module xt_bus_fifo_target #(
  parameter logic [19:0] BASE_ADDR   = 20'h00300,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          WAIT_STATES = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  xt_bus_fifo_target_if.slave        bus,
  input  logic [7:0]                 i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [7:0]                 o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_HOLD} state_t;

  function automatic logic [7:0] sat_count(input logic [AW:0] c);
    if (32'(c) > 32'd255) return 8'hFF;
    return 8'(c);
  endfunction

  state_t           r_state, w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_armed, r_is_read, r_is_dma;
  logic [1:0]       r_reg;
  logic [3:0]       r_ctrl;
  logic             r_tx_dropped, r_tc_seen, r_drq, r_irq;
  logic [7:0]       r_rdata;
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [AW:0]      r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;

  logic w_one_strobe, w_strobes_high, w_hit, w_dma_sel, w_cpu_sel, w_start;
  logic w_act, w_ready, w_drive;
  logic [AW:0] w_rx_count, w_tx_count;
  logic w_rx_full, w_rx_not_empty, w_tx_full, w_tx_empty;
  logic w_rx_push, w_rx_pop, w_tx_push_req, w_tx_push, w_tx_pop;
  logic [7:0] w_rd_mux;

  // Cycle selection: exactly one strobe low; DACK takes precedence over CPU decode.
  assign w_one_strobe   = bus.io_read_n ^ bus.io_write_n;
  assign w_strobes_high = bus.io_read_n & bus.io_write_n;
  assign w_hit          = (bus.address[19:2] == BASE_ADDR[19:2]);
  assign w_dma_sel      = ~bus.dma_acknowledge_n & w_one_strobe;
  assign w_cpu_sel      = ~bus.address_enable_n & w_hit & w_one_strobe;
  assign w_start        = r_armed & (w_dma_sel | w_cpu_sel);
  assign w_act          = (r_state == S_ACTIVE);

  assign w_rx_count     = r_rx_wr - r_rx_rd;
  assign w_tx_count     = r_tx_wr - r_tx_rd;
  assign w_rx_full      = (w_rx_count == DEPTH_V);
  assign w_tx_full      = (w_tx_count == DEPTH_V);
  assign w_rx_not_empty = (r_rx_wr != r_rx_rd);
  assign w_tx_empty     = (r_tx_wr == r_tx_rd);

  assign w_rx_push      = i_in_valid & ~w_rx_full;
  assign w_rx_pop       = w_act & r_is_read & (r_reg == 2'd0) & w_rx_not_empty;
  assign w_tx_push_req  = w_act & ~r_is_read & (r_reg == 2'd0);
  assign w_tx_push      = w_tx_push_req & ~w_tx_full;
  assign w_tx_pop       = ~w_tx_empty & i_out_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = (WAIT_STATES == 0) ? S_ACTIVE : S_WAIT;
      S_WAIT:   if (r_wait_cnt == WCW'(WAIT_STATES - 1)) w_next = S_ACTIVE;
      S_ACTIVE: w_next = S_HOLD;
      S_HOLD:   if (w_strobes_high) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_drive = 1'b0;
    case (r_state)
      S_WAIT:           begin w_ready = 1'b0; w_drive = r_is_read; end
      S_ACTIVE, S_HOLD: w_drive = r_is_read;
      default:          ;
    endcase
  end

  // A strobe still low when reset releases must go high before it can start a cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_armed    <= 1'b0;
      r_wait_cnt <= '0;
      r_is_read  <= 1'b0;
      r_is_dma   <= 1'b0;
      r_reg      <= 2'd0;
    end else begin
      if (w_strobes_high) r_armed <= 1'b1;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && w_start) begin
        r_is_read <= ~bus.io_read_n;
        r_is_dma  <= w_dma_sel;
        r_reg     <= w_dma_sel ? 2'd0 : bus.address[1:0];
      end
    end
  end

  always_comb begin
    case (r_reg)
      2'd0:    w_rd_mux = w_rx_not_empty ? r_rx_mem[r_rx_rd[AW-1:0]] : 8'hFF;
      2'd1:    w_rd_mux = {4'b0, r_tc_seen, r_tx_dropped, ~w_tx_full, w_rx_not_empty};
      2'd2:    w_rd_mux = {4'b0, r_ctrl};
      default: w_rd_mux = sat_count(w_rx_count);
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ctrl       <= 4'd0;
      r_tx_dropped <= 1'b0;
      r_tc_seen    <= 1'b0;
      r_rdata      <= 8'hFF;
    end else begin
      if (w_act & r_is_read) r_rdata <= w_rd_mux;
      if (w_act & ~r_is_read) begin
        if (r_reg == 2'd1) begin
          if (bus.internal_data_bus[2]) r_tx_dropped <= 1'b0;
          if (bus.internal_data_bus[3]) r_tc_seen    <= 1'b0;
        end
        if (r_reg == 2'd2) r_ctrl <= bus.internal_data_bus[3:0];
      end
      if (w_tx_push_req & w_tx_full) r_tx_dropped <= 1'b1;
      if (w_act & r_is_dma & ~bus.terminal_count_n) r_tc_seen <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= i_in_data;
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= bus.internal_data_bus;
  end

  // DRQ is withheld while a bus cycle is in flight and while DACK is asserted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_drq <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_drq <= r_ctrl[2] & ~r_tc_seen & (r_ctrl[3] ? ~w_tx_full : w_rx_not_empty)
               & (r_state == S_IDLE) & bus.dma_acknowledge_n;
      r_irq <= (r_ctrl[0] & w_rx_not_empty) | (r_ctrl[1] & w_tx_empty)
               | (r_ctrl[2] & r_tc_seen);
    end
  end

  assign bus.data_bus_out              = r_rdata;
  assign bus.data_bus_out_from_chipset = w_drive;
  assign bus.io_channel_ready          = w_ready;
  assign bus.dma_request               = r_drq;
  assign bus.interrupt_request         = r_irq;
  assign o_in_ready                    = ~w_rx_full;
  assign o_out_data                    = r_tx_mem[r_tx_rd[AW-1:0]];
  assign o_out_valid                   = ~w_tx_empty;
endmodule

// File: tb/tb_xt_bus_fifo_target.sv
// Directed bench for xt_bus_fifo_target: a register-access vector table plus hand-written
// sequences for the DMA, IRQ, TX-overflow and reset-mid-cycle cases.
module tb_xt_bus_fifo_target;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  int         n_tests = 0;
  int         n_fail  = 0;

  xt_bus_fifo_target_if bus_if ();

  xt_bus_fifo_target dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .bus         (bus_if),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [19:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One bus cycle with a fixed 6-cycle strobe; reports data, wait-state count, drive flag and DRQ one cycle after strobe fall.
  task automatic bus_cycle(input bit wr, input bit dma, input logic [19:0] a, input logic [7:0] d,
                           input bit tc, output logic [7:0] rd, output int waits,
                           output bit fc, output bit drq1);
    @(negedge clk);
    bus_if.address           = a;
    bus_if.internal_data_bus = d;
    bus_if.address_enable_n  = dma;
    bus_if.dma_acknowledge_n = ~dma;
    bus_if.terminal_count_n  = ~tc;
    if (wr) bus_if.io_write_n = 1'b0;
    else    bus_if.io_read_n  = 1'b0;
    waits = 0;
    fc    = 1'b0;
    drq1  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) drq1 = bus_if.dma_request;
      if (!bus_if.io_channel_ready) waits++;
      if (bus_if.data_bus_out_from_chipset) fc = 1'b1;
    end
    rd = bus_if.data_bus_out;
    bus_if.io_read_n         = 1'b1;
    bus_if.io_write_n        = 1'b1;
    bus_if.dma_acknowledge_n = 1'b1;
    bus_if.address_enable_n  = 1'b0;
    bus_if.terminal_count_n  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic io_rd(input string name, input logic [19:0] a, input logic [7:0] exp);
    logic [7:0] rd; int w; bit fc, dq;
    bus_cycle(1'b0, 1'b0, a, 8'h00, 1'b0, rd, w, fc, dq);
    check(name, {24'd0, rd}, {24'd0, exp});
  endtask

  task automatic io_wr(input logic [19:0] a, input logic [7:0] d);
    logic [7:0] rd; int w; bit fc, dq;
    bus_cycle(1'b1, 1'b0, a, d, 1'b0, rd, w, fc, dq);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         w, lows;
    bit         fc, dq;

    tv.push_back('{1'b0, 20'h00303, 8'h00, 8'h02});
    tv.push_back('{1'b0, 20'h00300, 8'h00, 8'h11});
    tv.push_back('{1'b0, 20'h00300, 8'h00, 8'h22});
    tv.push_back('{1'b0, 20'h00300, 8'h00, 8'hFF});
    tv.push_back('{1'b0, 20'h00301, 8'h00, 8'h02});
    tv.push_back('{1'b1, 20'h00302, 8'h0A, 8'h00});
    tv.push_back('{1'b0, 20'h00302, 8'h00, 8'h0A});
    tv.push_back('{1'b1, 20'h00302, 8'h00, 8'h00});
    tv.push_back('{1'b0, 20'h00302, 8'h00, 8'h00});
    tv.push_back('{1'b1, 20'h00303, 8'h55, 8'h00});
    tv.push_back('{1'b0, 20'h00303, 8'h00, 8'h00});
    tv.push_back('{1'b1, 20'h00301, 8'h0C, 8'h00});
    tv.push_back('{1'b0, 20'h00301, 8'h00, 8'h02});

    rst = 1'b1;
    bus_if.address = 20'h0; bus_if.internal_data_bus = 8'h0;
    bus_if.io_read_n = 1'b1; bus_if.io_write_n = 1'b1;
    bus_if.address_enable_n = 1'b0; bus_if.dma_acknowledge_n = 1'b1;
    bus_if.terminal_count_n = 1'b1;
    in_data = 8'h0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus_if.io_channel_ready}, 32'd1);
    check("rst_dbo", {24'd0, bus_if.data_bus_out}, 32'hFF);
    check("rst_fc", {31'd0, bus_if.data_bus_out_from_chipset}, 32'd0);
    check("rst_drq", {31'd0, bus_if.dma_request}, 32'd0);
    check("rst_irq", {31'd0, bus_if.interrupt_request}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single OUT with two wait states reaching the back-end
    bus_cycle(1'b1, 1'b0, 20'h00300, 8'h5A, 1'b0, rd, w, fc, dq);
    check("t1_waits", w, 2);
    check("t1_fc", {31'd0, fc}, 32'd0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data", {24'd0, out_data}, 32'h5A);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("t1_drained", {31'd0, out_valid}, 32'd0);

    push_rx(8'h11);
    push_rx(8'h22);
    for (int i = 0; i < tv.size(); i++) begin
      bus_cycle(tv[i].wr, 1'b0, tv[i].a, tv[i].d, 1'b0, rd, w, fc, dq);
      check($sformatf("vec%0d_waits", i), w, 2);
      check($sformatf("vec%0d_fc", i), {31'd0, fc}, {31'd0, ~tv[i].wr});
      if (!tv[i].wr) check($sformatf("vec%0d_data", i), {24'd0, rd}, {24'd0, tv[i].exp});
    end

    bus_cycle(1'b0, 1'b0, 20'h00304, 8'h00, 1'b0, rd, w, fc, dq);
    check("miss_waits", w, 0);
    check("miss_fc", {31'd0, fc}, 32'd0);

    @(negedge clk);
    bus_if.address = 20'h00300; bus_if.internal_data_bus = 8'h66;
    bus_if.io_read_n = 1'b0; bus_if.io_write_n = 1'b0;
    lows = 0;
    repeat (6) begin @(negedge clk); if (!bus_if.io_channel_ready) lows++; end
    bus_if.io_read_n = 1'b1; bus_if.io_write_n = 1'b1;
    repeat (2) @(negedge clk);
    check("both_low_waits", lows, 0);
    check("both_low_no_push", {31'd0, out_valid}, 32'd0);

    // TX overflow and sticky-drop clear
    for (int i = 0; i < 16; i++) io_wr(20'h00300, 8'h40 + 8'(i));
    io_wr(20'h00300, 8'hEE);
    io_rd("t3_status_full", 20'h00301, 8'h04);
    io_wr(20'h00301, 8'h04);
    io_rd("t3_status_clr", 20'h00301, 8'h00);
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_tx%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h40 + 8'(i)});
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("t3_tx_empty", {31'd0, out_valid}, 32'd0);

    // DMA RX->mem with terminal count on the third transfer
    io_wr(20'h00302, 8'h04);
    push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3); push_rx(8'hA4);
    @(negedge clk);
    check("t4_drq_on", {31'd0, bus_if.dma_request}, 32'd1);
    bus_cycle(1'b0, 1'b1, 20'h00000, 8'h00, 1'b0, rd, w, fc, dq);
    check("t4_dma1", {24'd0, rd}, 32'hA1);
    check("t4_drq_dack", {31'd0, dq}, 32'd0);
    check("t4_fc", {31'd0, fc}, 32'd1);
    check("t4_drq_again", {31'd0, bus_if.dma_request}, 32'd1);
    bus_cycle(1'b0, 1'b1, 20'h00000, 8'h00, 1'b0, rd, w, fc, dq);
    check("t4_dma2", {24'd0, rd}, 32'hA2);
    bus_cycle(1'b0, 1'b1, 20'h00000, 8'h00, 1'b1, rd, w, fc, dq);
    check("t4_dma3", {24'd0, rd}, 32'hA3);
    check("t4_drq_tc", {31'd0, bus_if.dma_request}, 32'd0);
    check("t4_irq_tc", {31'd0, bus_if.interrupt_request}, 32'd1);
    io_rd("t4_status_tc", 20'h00301, 8'h0B);
    io_wr(20'h00301, 8'h08);
    io_rd("t4_status_clr", 20'h00301, 8'h03);
    io_wr(20'h00302, 8'h00);
    io_rd("t4_last", 20'h00300, 8'hA4);

    io_wr(20'h00302, 8'h0C);
    @(negedge clk);
    check("dmaw_drq", {31'd0, bus_if.dma_request}, 32'd1);
    bus_cycle(1'b1, 1'b1, 20'h00000, 8'h3C, 1'b0, rd, w, fc, dq);
    check("dmaw_waits", w, 2);
    check("dmaw_out", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h3C});
    io_wr(20'h00302, 8'h00);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // RX IRQ latency
    io_wr(20'h00302, 8'h01);
    check("t5_irq_idle", {31'd0, bus_if.interrupt_request}, 32'd0);
    push_rx(8'h77);
    check("t5_irq_lat", {31'd0, bus_if.interrupt_request}, 32'd0);
    @(negedge clk);
    check("t5_irq_set", {31'd0, bus_if.interrupt_request}, 32'd1);
    io_rd("t5_pop", 20'h00300, 8'h77);
    check("t5_irq_clr", {31'd0, bus_if.interrupt_request}, 32'd0);

    // Reset during a WAIT state with the read strobe still low
    push_rx(8'h99);
    @(negedge clk);
    bus_if.address = 20'h00300; bus_if.io_read_n = 1'b0;
    @(negedge clk);
    check("t6_in_wait", {31'd0, bus_if.io_channel_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", {31'd0, bus_if.io_channel_ready}, 32'd1);
    check("t6_rst_fc", {31'd0, bus_if.data_bus_out_from_chipset}, 32'd0);
    rst = 1'b0;
    lows = 0;
    repeat (4) begin @(negedge clk); if (!bus_if.io_channel_ready) lows++; end
    check("t6_unarmed", lows, 0);
    check("t6_irq", {31'd0, bus_if.interrupt_request}, 32'd0);
    bus_if.io_read_n = 1'b1;
    @(negedge clk);
    push_rx(8'h99);
    io_rd("t6_count", 20'h00303, 8'h01);
    bus_cycle(1'b0, 1'b0, 20'h00300, 8'h00, 1'b0, rd, w, fc, dq);
    check("t6_read", {24'd0, rd}, 32'h99);
    check("t6_waits", w, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
